blink_meter: RTL and testbench

BLINK_METER -- requirements
Module: blink_meter

---
 rtl/blink_meter.sv | 183 ++++++++++++++++++
 tb/tb_blink_meter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/blink_meter.sv
// ---------------------------------------------------------------------------
// blink_meter
//   Measures the half-period of a slow asynchronous square wave (e.g. a
//   blinking LED) in CLOCK_50 cycles, flags whether it lies within TOL of
//   EXPECT, and declares the input stuck after TIMEOUT cycles without an edge.
//
// Ports
//   CLOCK_50     in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   sig_in       in   1      monitored square wave, asynchronous
//   half_period  out  CNT_W  last measured interval between accepted edges
//   period_valid out  1      one-cycle pulse when half_period/in_range update
//   in_range     out  1      |half_period - EXPECT| <= TOL
//   timeout      out  1      high while the input is considered stuck
//   edge_count   out  16     accepted edges since reset (wraps)
//
// Configuration
//   BLINK_METER_GLITCH_FILTER_EN : when defined, the synchronized level must
//   differ from the filtered level for FILT consecutive cycles before the
//   filtered level follows it. Shorter pulses are dropped.
// ---------------------------------------------------------------------------
module blink_meter #(
    parameter int CNT_W   = 26,
    parameter int EXPECT  = 501,
    parameter int TOL     = 2,
    parameter int TIMEOUT = 1000,
    parameter int FILT    = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             in_range,
    output logic             timeout,
    output logic [15:0]      edge_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             lvl_s;
    logic             lvl_d_r;
    logic             edge_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W:0]   cnt_inc_s;
    logic [CNT_W-1:0] meas_s;
    logic [CNT_W:0]   meas_w_s;
    logic [CNT_W:0]   diff_s;
    logic             in_range_s;
    logic             timeout_hit_s;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef BLINK_METER_GLITCH_FILTER_EN
    localparam int FW = (FILT < 2) ? 1 : $clog2(FILT);

    logic          filt_r;
    logic [FW-1:0] stab_r;

    // Glitch filter: follow the synchronized level only after it has
    // disagreed with the filtered level for FILT consecutive cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_r <= 1'b0;
            stab_r <= {FW{1'b0}};
        end else if (sync2_r != filt_r) begin
            if (stab_r == FW'(FILT - 1)) begin
                filt_r <= sync2_r;
                stab_r <= {FW{1'b0}};
            end else begin
                stab_r <= stab_r + FW'(1);
            end
        end else begin
            stab_r <= {FW{1'b0}};
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync2_r;
`endif

    // Delayed copy of the detection level for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lvl_d_r <= 1'b0;
        end else begin
            lvl_d_r <= lvl_s;
        end
    end

    assign edge_s = (lvl_s != lvl_d_r);

    // Interval arithmetic: saturating count+1, and the range check done one
    // bit wider than the counter so neither subtraction can wrap.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        if (cnt_inc_s[CNT_W]) begin
            meas_s = {CNT_W{1'b1}};
        end else begin
            meas_s = cnt_inc_s[CNT_W-1:0];
        end
        meas_w_s = {1'b0, meas_s};
        if (meas_w_s >= (CNT_W+1)'(EXPECT)) begin
            diff_s = meas_w_s - (CNT_W+1)'(EXPECT);
        end else begin
            diff_s = (CNT_W+1)'(EXPECT) - meas_w_s;
        end
        in_range_s    = (diff_s <= (CNT_W+1)'(TOL));
        timeout_hit_s = (cnt_inc_s == (CNT_W+1)'(TIMEOUT));
    end

    // Measurement state machine with registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            half_period  <= {CNT_W{1'b0}};
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            timeout      <= 1'b0;
            edge_count   <= 16'd0;
        end else begin
            period_valid <= 1'b0;
            if (edge_s) begin
                edge_count <= edge_count + 16'd1;
            end
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (edge_s) begin
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the threshold cycle still counts as a
                    // measurement, so it is tested first.
                    if (edge_s) begin
                        half_period  <= meas_s;
                        in_range     <= in_range_s;
                        period_valid <= 1'b1;
                        cnt_r        <= {CNT_W{1'b0}};
                    end else if (timeout_hit_s) begin
                        state_r <= STUCK;
                        timeout <= 1'b1;
                    end else begin
                        cnt_r <= meas_s;
                    end
                end
                STUCK: begin
                    // The interval spanning the stall is not reported.
                    if (edge_s) begin
                        state_r <= MEASURE;
                        cnt_r   <= {CNT_W{1'b0}};
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_meter.sv
// ---------------------------------------------------------------------------
// tb_blink_meter
//   Directed and randomized stimulus for blink_meter, checked every cycle
//   against an event-level reference: each input change becomes an accepted
//   edge a fixed latency later, and the reported interval is simply the
//   difference between accepted-edge cycle numbers.
// ---------------------------------------------------------------------------
module tb_blink_meter;

    localparam int CNT_W   = 26;
    localparam int EXPECT  = 501;
    localparam int TOL     = 2;
    localparam int TIMEOUT = 1000;
    localparam int FILT    = 4;
`ifdef BLINK_METER_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT;
`else
    localparam int LAT = 3;
`endif

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic             sig_in   = 1'b0;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             in_range;
    logic             timeout;
    logic [15:0]      edge_count;

    blink_meter #(
        .CNT_W  (CNT_W),
        .EXPECT (EXPECT),
        .TOL    (TOL),
        .TIMEOUT(TIMEOUT),
        .FILT   (FILT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .sig_in      (sig_in),
        .half_period (half_period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .timeout     (timeout),
        .edge_count  (edge_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int accept_q[$];

    // Reference model state: 0 = no edge yet, 1 = measuring, 2 = stalled.
    int mode      = 0;
    int last_edge = 0;
    int m_hp      = 0;
    int m_ec      = 0;
    bit m_inr     = 1'b0;
    bit m_pv      = 1'b0;
    bit m_to      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit was_rst;
        int d;
        @(posedge CLOCK_50);
        was_rst = reset;
        cyc++;
        @(negedge CLOCK_50);
        m_pv = 1'b0;
        if (was_rst) begin
            mode = 0; m_hp = 0; m_ec = 0; m_inr = 1'b0; m_to = 1'b0;
            accept_q.delete();
        end else if (accept_q.size() > 0 && accept_q[0] == cyc) begin
            void'(accept_q.pop_front());
            m_ec = (m_ec + 1) % 65536;
            if (mode == 1) begin
                m_hp  = cyc - last_edge;
                d     = (m_hp > EXPECT) ? m_hp - EXPECT : EXPECT - m_hp;
                m_inr = (d <= TOL);
                m_pv  = 1'b1;
            end
            mode      = 1;
            m_to      = 1'b0;
            last_edge = cyc;
        end else if (mode == 1 && cyc - last_edge == TIMEOUT) begin
            mode = 2;
            m_to = 1'b1;
        end
        chk("half_period",  32'(half_period),  32'(m_hp));
        chk("period_valid", 32'(period_valid), 32'(m_pv));
        chk("in_range",     32'(in_range),     32'(m_inr));
        chk("timeout",      32'(timeout),      32'(m_to));
        chk("edge_count",   32'(edge_count),   32'(m_ec));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic toggle();
        sig_in = ~sig_in;
        accept_q.push_back(cyc + LAT);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        if (sig_in) accept_q.push_back(cyc + LAT);
    endtask

    initial begin
        int gap;
        // Reset state.
        reset  = 1'b1;
        sig_in = 1'b0;
        run(3);

        // High level at release counts as the first edge, then 9 toggles at 501.
        sig_in = 1'b1;
        release_reset();
        run(LAT);
        chk("first_edge_count", 32'(edge_count), 32'd1);
        run(501 - LAT);
        for (int i = 0; i < 9; i++) begin
            toggle();
            run(501);
        end
        chk("ten_edges", 32'(edge_count), 32'd10);
        chk("hp_501", 32'(half_period), 32'd501);

        // Out of range and just inside the lower tolerance.
        for (int i = 0; i < 5; i++) begin toggle(); run(510); end
        chk("hp_510", 32'(half_period), 32'd510);
        for (int i = 0; i < 5; i++) begin toggle(); run(499); end
        chk("hp_499", 32'(half_period), 32'd499);

        // Stall, recovery without a report, then a valid measurement.
        run(1200);
        chk("stuck", 32'(timeout), 32'd1);
        toggle(); run(501);
        toggle(); run(501);

        // Edge exactly on the threshold wins; one cycle later it stalls first.
        toggle(); run(1000);
        toggle(); run(1001);
        toggle(); run(20);

        // Reset in the middle of an interval.
        reset = 1'b1;
        run(2);
        release_reset();
        run(600);
        toggle(); run(501);
        toggle(); run(10);

`ifdef BLINK_METER_GLITCH_FILTER_EN
        // A 2-cycle pulse must vanish in the filter.
        sig_in = ~sig_in; run(2);
        sig_in = ~sig_in; run(20);
`endif

        // Randomized intervals around the nominal period and the timeout.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) gap = $urandom_range(995, 1005);
            else                           gap = $urandom_range(495, 507);
            toggle();
            run(gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
